// File: rtl/calc_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
//   Shared types and constants for the calculator bank store.
//   - calc_state_t : clear-engine state (CLEAR while wiping the banks,
//                    IDLE while the read/write ports are live)
//   - DEF_*        : default widths and depths for the two banks
//   - max_of()     : elaboration-time helper that sizes the clear sweep
// ---------------------------------------------------------------------------
package calc_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } calc_state_t;

   localparam int DEF_DATA_W     = 8;
   localparam int DEF_INST_W     = 8;
   localparam int DEF_DATA_DEPTH = 16;
   localparam int DEF_INST_DEPTH = 16;

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/calc_mem_bank.sv
// ---------------------------------------------------------------------------
// calc_mem_bank
//   One storage bank: DEPTH words of W bits, one write port, one registered
//   read port with a valid pulse, an out-of-range detector, and a
//   clear-write input driven by the top-level clear engine.
//
//   Optional feature (macro CALC_MEM_BYPASS_EN):
//     defined     : a read and a write to the same address in one cycle
//                   return the new write data (write-first).
//     not defined : the read returns the previously stored word
//                   (read-first); the write still lands.
//
// Ports
//   clk, rst        clock and synchronous active-high reset
//   clr_en          1 while the clear engine owns the bank
//   clr_idx[IW]     entry being cleared; ignored when >= DEPTH
//   we/waddr/wdata  write port (already gated by the caller)
//   re/raddr        read request (already gated by the caller)
//   rdata           registered read data, holds while no read is accepted
//   rvalid          1-cycle pulse one cycle after an accepted read
//   err             1-cycle pulse: the previous cycle's op used addr >= DEPTH
//
// Handshake: an op is accepted whenever its enable is high at a rising
// edge; there is no back-pressure. rvalid/rdata follow one edge later.
// ---------------------------------------------------------------------------
module calc_mem_bank #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int IW    = AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_en,
   input  logic [IW-1:0] clr_idx,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata,
   output logic          rvalid,
   output logic          err
);

   // Depth widened by one bit so that a non power-of-two depth compares
   // cleanly against full-width addresses.
   localparam logic [AW:0] DEPTH_A = (AW+1)'(DEPTH);
   localparam logic [IW:0] DEPTH_C = (IW+1)'(DEPTH);

   logic [W-1:0] mem [DEPTH];

   logic         w_in_range;
   logic         r_in_range;
   logic         c_in_range;
   logic [W-1:0] rd_word;

   assign w_in_range = ({1'b0, waddr}   < DEPTH_A);
   assign r_in_range = ({1'b0, raddr}   < DEPTH_A);
   assign c_in_range = ({1'b0, clr_idx} < DEPTH_C);

   // Word presented to the read register. Out-of-range reads return 0.
   always_comb begin
      rd_word = '0;
      if (r_in_range) begin
         rd_word = mem[raddr];
`ifdef CALC_MEM_BYPASS_EN
         if (we && w_in_range && (waddr == raddr)) begin
            rd_word = wdata;
         end
`endif
      end
   end

   // Storage has no reset; the clear engine zeroes it after every reset.
   // clr_en and we are never both high, so the two writes cannot collide.
   always_ff @(posedge clk) begin
      if (clr_en && c_in_range) begin
         mem[clr_idx[AW-1:0]] <= '0;
      end
      if (we && w_in_range) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata  <= '0;
         rvalid <= 1'b0;
         err    <= 1'b0;
      end else begin
         rvalid <= re;
         err    <= (we && !w_in_range) || (re && !r_in_range);
         if (re) begin
            rdata <= rd_word;
         end
      end
   end

endmodule

// File: rtl/calc_bank_mem.sv
// ---------------------------------------------------------------------------
// calc_bank_mem
//   Data / instruction store for the calculator datapath: two independent
//   banks (calc_mem_bank) plus a sequential clear engine that zeroes both
//   banks after reset or on request.
//
//   Optional feature (macro CALC_MEM_BYPASS_EN): write-first behaviour for a
//   same-address read and write in one cycle; otherwise read-first.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   clr_req                          start a full clear (honoured in IDLE)
//   busy                             1 while the clear engine runs
//   data_we/data_waddr/data_wdata    data bank write port
//   data_re/data_raddr               data bank read request
//   data_rdata/data_rvalid           data read result, one cycle later
//   inst_we/inst_waddr/inst_wdata    instruction bank write port
//   inst_re/inst_raddr               instruction bank read request
//   inst_rdata/inst_rvalid           instruction read result, one cycle later
//   addr_err                         1-cycle pulse: an accepted op was out of range
//   state_dbg                        current clear-engine state
//
// Handshake: every *_we / *_re is accepted at a rising edge while the engine
// is IDLE and rst is low; in CLEAR they are silently dropped. Read results
// appear as a single-cycle *_rvalid pulse with *_rdata after the next edge.
// ---------------------------------------------------------------------------
module calc_bank_mem
   import calc_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int INST_W     = DEF_INST_W,
   parameter int DATA_DEPTH = DEF_DATA_DEPTH,
   parameter int INST_DEPTH = DEF_INST_DEPTH,
   localparam int DATA_AW   = $clog2(DATA_DEPTH),
   localparam int INST_AW   = $clog2(INST_DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_req,
   output logic               busy,
   input  logic               data_we,
   input  logic [DATA_AW-1:0] data_waddr,
   input  logic [DATA_W-1:0]  data_wdata,
   input  logic               data_re,
   input  logic [DATA_AW-1:0] data_raddr,
   output logic [DATA_W-1:0]  data_rdata,
   output logic               data_rvalid,
   input  logic               inst_we,
   input  logic [INST_AW-1:0] inst_waddr,
   input  logic [INST_W-1:0]  inst_wdata,
   input  logic               inst_re,
   input  logic [INST_AW-1:0] inst_raddr,
   output logic [INST_W-1:0]  inst_rdata,
   output logic               inst_rvalid,
   output logic               addr_err,
   output calc_state_t        state_dbg
);

   // The clear sweep covers the deeper bank; the shallower bank ignores
   // indices beyond its own depth.
   localparam int                CLR_N    = max_of(DATA_DEPTH, INST_DEPTH);
   localparam int                CLR_AW   = $clog2(CLR_N);
   localparam logic [CLR_AW-1:0] CLR_LAST = CLR_AW'(CLR_N - 1);

   calc_state_t       state;
   logic [CLR_AW-1:0] idx;
   logic              ops_en;
   logic              clr_en;
   logic              data_err;
   logic              inst_err;

   // Port ops only reach the banks while IDLE and out of reset.
   assign ops_en    = (state == IDLE) && !rst;
   assign clr_en    = (state == CLEAR) && !rst;
   assign state_dbg = state;
   assign addr_err  = data_err | inst_err;

   // Clear engine. busy is registered alongside the state so it is high for
   // exactly CLR_N cycles after rst falls or after clr_req is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         idx   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            CLEAR: begin
               if (idx == CLR_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  idx   <= '0;
               end else begin
                  idx <= idx + CLR_AW'(1);
               end
            end
            IDLE: begin
               // Ops presented alongside clr_req are still executed this cycle.
               if (clr_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  idx   <= '0;
               end
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
               idx   <= '0;
            end
         endcase
      end
   end

   calc_mem_bank #(
      .W     (DATA_W),
      .DEPTH (DATA_DEPTH),
      .AW    (DATA_AW),
      .IW    (CLR_AW)
   ) u_data_bank (
      .clk     (clk),
      .rst     (rst),
      .clr_en  (clr_en),
      .clr_idx (idx),
      .we      (data_we && ops_en),
      .waddr   (data_waddr),
      .wdata   (data_wdata),
      .re      (data_re && ops_en),
      .raddr   (data_raddr),
      .rdata   (data_rdata),
      .rvalid  (data_rvalid),
      .err     (data_err)
   );

   calc_mem_bank #(
      .W     (INST_W),
      .DEPTH (INST_DEPTH),
      .AW    (INST_AW),
      .IW    (CLR_AW)
   ) u_inst_bank (
      .clk     (clk),
      .rst     (rst),
      .clr_en  (clr_en),
      .clr_idx (idx),
      .we      (inst_we && ops_en),
      .waddr   (inst_waddr),
      .wdata   (inst_wdata),
      .re      (inst_re && ops_en),
      .raddr   (inst_raddr),
      .rdata   (inst_rdata),
      .rvalid  (inst_rvalid),
      .err     (inst_err)
   );

endmodule

// File: tb/tb_calc_bank_mem.sv
// ---------------------------------------------------------------------------
// tb_calc_bank_mem
//   Bench for calc_bank_mem with DATA_DEPTH=16, INST_DEPTH=12 (8-bit words).
//   A behavioural model tracks both banks as plain arrays and a countdown of
//   remaining clear cycles; read results go through per-bank expected queues.
// ---------------------------------------------------------------------------
module tb_calc_bank_mem;
   import calc_pkg::*;

   localparam int DW    = 8;
   localparam int IW    = 8;
   localparam int DD    = 16;
   localparam int ID    = 12;
   localparam int CLR_N = 16;
`ifdef CALC_MEM_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          clr_req = 1'b0;
   logic          busy;
   logic          data_we = 1'b0;
   logic [3:0]    data_waddr = '0;
   logic [DW-1:0] data_wdata = '0;
   logic          data_re = 1'b0;
   logic [3:0]    data_raddr = '0;
   logic [DW-1:0] data_rdata;
   logic          data_rvalid;
   logic          inst_we = 1'b0;
   logic [3:0]    inst_waddr = '0;
   logic [IW-1:0] inst_wdata = '0;
   logic          inst_re = 1'b0;
   logic [3:0]    inst_raddr = '0;
   logic [IW-1:0] inst_rdata;
   logic          inst_rvalid;
   logic          addr_err;
   calc_state_t   state_dbg;

   calc_bank_mem #(
      .DATA_W(DW), .INST_W(IW), .DATA_DEPTH(DD), .INST_DEPTH(ID)
   ) dut (
      .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy),
      .data_we(data_we), .data_waddr(data_waddr), .data_wdata(data_wdata),
      .data_re(data_re), .data_raddr(data_raddr),
      .data_rdata(data_rdata), .data_rvalid(data_rvalid),
      .inst_we(inst_we), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
      .inst_re(inst_re), .inst_raddr(inst_raddr),
      .inst_rdata(inst_rdata), .inst_rvalid(inst_rvalid),
      .addr_err(addr_err), .state_dbg(state_dbg)
   );

   // ---------------- stimulus records ----------------
   typedef struct {
      bit         rst;
      bit         clr;
      bit         dwe;
      logic [3:0] dwa;
      logic [7:0] dwd;
      bit         dre;
      logic [3:0] dra;
      bit         iwe;
      logic [3:0] iwa;
      logic [7:0] iwd;
      bit         ire;
      logic [3:0] ira;
   } op_t;

   typedef struct {
      op_t        op;
      bit         edrv;
      logic [7:0] edrd;
      bit         eirv;
      logic [7:0] eird;
      bit         eerr;
   } vec_t;

   // ---------------- reference model ----------------
   logic [7:0] dmem [DD];
   logic [7:0] imem [ID];
   int         m_left = 0;
   bit         e_busy = 1'b1;
   bit         e_drv = 1'b0;
   bit         e_irv = 1'b0;
   bit         e_err = 1'b0;
   logic [7:0] e_drd = '0;
   logic [7:0] e_ird = '0;

   // ---------------- scoreboard ----------------
   logic [DW-1:0] d_exp_q[$];
   logic [IW-1:0] i_exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic op_t nop();
      op_t o;
      o.rst = 1'b0; o.clr = 1'b0;
      o.dwe = 1'b0; o.dwa = '0; o.dwd = '0; o.dre = 1'b0; o.dra = '0;
      o.iwe = 1'b0; o.iwa = '0; o.iwd = '0; o.ire = 1'b0; o.ira = '0;
      return o;
   endfunction

   function automatic op_t mkop(input bit dwe, input logic [3:0] dwa, input logic [7:0] dwd,
                                input bit dre, input logic [3:0] dra,
                                input bit iwe, input logic [3:0] iwa, input logic [7:0] iwd,
                                input bit ire, input logic [3:0] ira);
      op_t o = nop();
      o.dwe = dwe; o.dwa = dwa; o.dwd = dwd; o.dre = dre; o.dra = dra;
      o.iwe = iwe; o.iwa = iwa; o.iwd = iwd; o.ire = ire; o.ira = ira;
      return o;
   endfunction

   function automatic vec_t mkvec(input op_t o, input bit drv, input logic [7:0] drd,
                                  input bit irv, input logic [7:0] ird, input bit err);
      vec_t v;
      v.op = o; v.edrv = drv; v.edrd = drd; v.eirv = irv; v.eird = ird; v.eerr = err;
      return v;
   endfunction

   function automatic op_t rand_op();
      op_t o = nop();
      o.dwe = 1'($urandom_range(0, 1));
      o.dwa = 4'($urandom_range(0, 15));
      o.dwd = 8'($urandom_range(0, 255));
      o.dre = 1'($urandom_range(0, 1));
      o.dra = ($urandom_range(0, 3) == 0) ? o.dwa : 4'($urandom_range(0, 15));
      o.iwe = 1'($urandom_range(0, 1));
      o.iwa = 4'($urandom_range(0, 15));
      o.iwd = 8'($urandom_range(0, 255));
      o.ire = 1'($urandom_range(0, 1));
      o.ira = ($urandom_range(0, 3) == 0) ? o.iwa : 4'($urandom_range(0, 15));
      return o;
   endfunction

   // Predict the outputs after the coming edge. While a clear is pending,
   // nothing can observe the banks, so the model wipes them at once.
   task automatic model_step(input op_t o);
      if (o.rst) begin
         m_left = CLR_N;
         e_busy = 1'b1;
         e_drv = 1'b0; e_irv = 1'b0; e_err = 1'b0;
         e_drd = '0;   e_ird = '0;
         d_exp_q.delete();
         i_exp_q.delete();
         for (int i = 0; i < DD; i++) dmem[i] = '0;
         for (int i = 0; i < ID; i++) imem[i] = '0;
      end else if (m_left > 0) begin
         m_left--;
         e_busy = (m_left > 0);
         e_drv = 1'b0; e_irv = 1'b0; e_err = 1'b0;
      end else begin
         e_err = 1'b0;
         e_drv = o.dre;
         if (o.dre) begin
            if (int'(o.dra) < DD)
               e_drd = (BYP && o.dwe && o.dwa == o.dra) ? o.dwd : dmem[o.dra];
            else begin
               e_drd = '0;
               e_err = 1'b1;
            end
            d_exp_q.push_back(e_drd);
         end
         e_irv = o.ire;
         if (o.ire) begin
            if (int'(o.ira) < ID)
               e_ird = (BYP && o.iwe && o.iwa == o.ira) ? o.iwd : imem[o.ira];
            else begin
               e_ird = '0;
               e_err = 1'b1;
            end
            i_exp_q.push_back(e_ird);
         end
         if (o.dwe) begin
            if (int'(o.dwa) < DD) dmem[o.dwa] = o.dwd;
            else e_err = 1'b1;
         end
         if (o.iwe) begin
            if (int'(o.iwa) < ID) imem[o.iwa] = o.iwd;
            else e_err = 1'b1;
         end
         if (o.clr) begin
            m_left = CLR_N;
            e_busy = 1'b1;
            for (int i = 0; i < DD; i++) dmem[i] = '0;
            for (int i = 0; i < ID; i++) imem[i] = '0;
         end
      end
   endtask

   task automatic check_outputs();
      logic [7:0] exp_v;
      check("busy", 32'(busy), 32'(e_busy));
      check("state_dbg", 32'(state_dbg), 32'(e_busy ? CLEAR : IDLE));
      check("data_rvalid", 32'(data_rvalid), 32'(e_drv));
      check("inst_rvalid", 32'(inst_rvalid), 32'(e_irv));
      check("addr_err", 32'(addr_err), 32'(e_err));
      check("data_rdata_hold", 32'(data_rdata), 32'(e_drd));
      check("inst_rdata_hold", 32'(inst_rdata), 32'(e_ird));
      if (data_rvalid === 1'b1) begin
         if (d_exp_q.size() == 0) check("data_sb_unexpected", 32'(data_rvalid), 32'(0));
         else begin
            exp_v = d_exp_q.pop_front();
            check("data_sb", 32'(data_rdata), 32'(exp_v));
         end
      end
      if (inst_rvalid === 1'b1) begin
         if (i_exp_q.size() == 0) check("inst_sb_unexpected", 32'(inst_rvalid), 32'(0));
         else begin
            exp_v = i_exp_q.pop_front();
            check("inst_sb", 32'(inst_rdata), 32'(exp_v));
         end
      end
      if (d_exp_q.size() != 0) begin
         check("data_sb_missing", 32'(d_exp_q.size()), 32'(0));
         d_exp_q.delete();
      end
      if (i_exp_q.size() != 0) begin
         check("inst_sb_missing", 32'(i_exp_q.size()), 32'(0));
         i_exp_q.delete();
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input op_t o);
      rst = o.rst; clr_req = o.clr;
      data_we = o.dwe; data_waddr = o.dwa; data_wdata = o.dwd;
      data_re = o.dre; data_raddr = o.dra;
      inst_we = o.iwe; inst_waddr = o.iwa; inst_wdata = o.iwd;
      inst_re = o.ire; inst_raddr = o.ira;
      model_step(o);
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   // Count cycles with busy=1, starting with the sample already taken.
   task automatic measure_busy(input string name);
      int n = 0;
      if (busy === 1'b1) n++;
      for (int k = 0; k < 40; k++) begin
         step(nop());
         if (busy === 1'b1) n++;
         else break;
      end
      check(name, 32'(n), 32'(CLR_N));
   endtask

   // ---------------- test ----------------
   vec_t vt [10];
   op_t  o;

   initial begin
      vt[0] = mkvec(mkop(1, 4'd3, 8'hA5, 0, 4'd0, 1, 4'd3, 8'h3C, 0, 4'd0), 0, 8'h00, 0, 8'h00, 0);
      vt[1] = mkvec(mkop(0, 4'd0, 8'h00, 1, 4'd3, 0, 4'd0, 8'h00, 1, 4'd3), 1, 8'hA5, 1, 8'h3C, 0);
      vt[2] = mkvec(mkop(1, 4'd5, 8'h11, 0, 4'd0, 0, 4'd0, 8'h00, 0, 4'd0), 0, 8'hA5, 0, 8'h3C, 0);
      vt[3] = mkvec(mkop(1, 4'd5, 8'h22, 1, 4'd5, 0, 4'd0, 8'h00, 0, 4'd0), 1,
                    BYP ? 8'h22 : 8'h11, 0, 8'h3C, 0);
      vt[4] = mkvec(mkop(0, 4'd0, 8'h00, 1, 4'd5, 0, 4'd0, 8'h00, 0, 4'd0), 1, 8'h22, 0, 8'h3C, 0);
      vt[5] = mkvec(mkop(0, 4'd0, 8'h00, 0, 4'd0, 0, 4'd0, 8'h00, 1, 4'd13), 0, 8'h22, 1, 8'h00, 1);
      vt[6] = mkvec(mkop(0, 4'd0, 8'h00, 0, 4'd0, 0, 4'd0, 8'h00, 0, 4'd0), 0, 8'h22, 0, 8'h00, 0);
      vt[7] = mkvec(mkop(0, 4'd0, 8'h00, 0, 4'd0, 1, 4'd14, 8'h55, 0, 4'd0), 0, 8'h22, 0, 8'h00, 1);
      vt[8] = mkvec(mkop(0, 4'd0, 8'h00, 0, 4'd0, 0, 4'd0, 8'h00, 1, 4'd14), 0, 8'h22, 1, 8'h00, 1);
      vt[9] = mkvec(mkop(0, 4'd0, 8'h00, 0, 4'd0, 0, 4'd0, 8'h00, 1, 4'd3), 0, 8'h22, 1, 8'h3C, 0);

      // Reset for one cycle, then busy must last exactly CLR_N cycles.
      o = nop(); o.rst = 1'b1;
      step(o);
      check("rst_data_rdata", 32'(data_rdata), 32'(0));
      check("rst_busy", 32'(busy), 32'(1));
      measure_busy("busy_len_after_rst");

      // Every address of both banks now reads 0 with rvalid.
      for (int a = 0; a < 16; a++) step(mkop(0, 4'd0, 8'h00, 1, 4'(a), 0, 4'd0, 8'h00, 1, 4'(a)));

      // Directed vectors.
      for (int i = 0; i < 10; i++) begin
         step(vt[i].op);
         check($sformatf("vec%0d_drv", i), 32'(data_rvalid), 32'(vt[i].edrv));
         check($sformatf("vec%0d_drd", i), 32'(data_rdata), 32'(vt[i].edrd));
         check($sformatf("vec%0d_irv", i), 32'(inst_rvalid), 32'(vt[i].eirv));
         check($sformatf("vec%0d_ird", i), 32'(inst_rdata), 32'(vt[i].eird));
         check($sformatf("vec%0d_err", i), 32'(addr_err), 32'(vt[i].eerr));
      end

      // Fill, then clr_req together with data write 0x7F at address 2.
      for (int a = 0; a < 16; a++)
         step(mkop(1, 4'(a), 8'(8'h40 + a), 0, 4'd0, 1, 4'(a % ID), 8'(8'h80 + a), 0, 4'd0));
      o = mkop(1, 4'd2, 8'h7F, 1, 4'd2, 0, 4'd0, 8'h00, 0, 4'd0);
      o.clr = 1'b1;
      step(o);
      check("clr_busy_next", 32'(busy), 32'(1));
      check("clr_same_cycle_read", 32'(data_rdata), 32'(BYP ? 8'h7F : 8'h42));
      for (int k = 0; k < 40 && busy === 1'b1; k++) begin
         step(mkop(0, 4'd0, 8'h00, 1, 4'd2, 0, 4'd0, 8'h00, 1, 4'd2));
         if (busy === 1'b1) check("clr_read_no_rvalid", 32'(data_rvalid), 32'(0));
      end
      check("clr_done", 32'(busy), 32'(0));
      step(mkop(0, 4'd0, 8'h00, 1, 4'd2, 0, 4'd0, 8'h00, 1, 4'd2));
      check("clr_addr2_data", 32'(data_rdata), 32'(0));
      check("clr_addr2_rvalid", 32'(data_rvalid), 32'(1));

      // rst when the clear engine has reached index 7: full restart.
      o = nop(); o.clr = 1'b1;
      step(o);
      for (int k = 0; k < 7; k++) step(nop());
      o = nop(); o.rst = 1'b1;
      step(o);
      measure_busy("busy_len_after_mid_rst");

      // Randomised traffic with occasional clears and resets.
      for (int n = 0; n < 800; n++) begin
         o = rand_op();
         if ($urandom_range(0, 59) == 0) o.clr = 1'b1;
         if ($urandom_range(0, 249) == 0) o.rst = 1'b1;
         step(o);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
